// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, framing-error and busy flags.
// Samples mid-bit by timing from the detected start edge; a held-low line yields one frame_err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sync, r_rx_s;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_ferr, w_ferr_nxt;
    logic          w_bit_end, w_half_end;

    assign w_bit_end  = r_cnt == BIT_LAST;
    assign w_half_end = r_cnt == HALF_LAST;

    // Synchronizer flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_sync <= rx;
            r_rx_s <= r_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) w_state_nxt = START;
            end
            START: begin
                if (w_half_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_shreg_nxt   = {r_rx_s, r_shreg[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cnt_nxt = '0;
                if (r_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = r_state != IDLE;
endmodule
